regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback producers: source 0 is the ALU/execute result and source 1 is the LSU load return. Each source feeds its own small FIFO. A round-robin arbiter picks one FIFO head per cycle. The winner is registered onto the register file's destination-register, write-enable and write-data inputs. Writes to x0 are discarded at the FIFO input.

---
 rtl/rv_wb_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// Shared writeback definitions for the register-file write-port arbiter.
// Holds the default widths and source indices. It also provides the writeback
// entry type and the round-robin pick helper that the arbiter uses.
package rv_wb_pkg;

  localparam int REG_AW  = 5;
  localparam int DATA_W  = 32;
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Returns 1 when the LSU head should win this cycle.
  // last_grant is 1 when the LSU won the most recent granted cycle.
  // A lone requester always wins. Under contention the source that
  // did not win last time is picked.
  function automatic logic rr_pick_lsu(input logic alu_ne,
                                       input logic lsu_ne,
                                       input logic last_grant);
    return lsu_ne && (!alu_ne || !last_grant);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for one writeback source.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (pointers and count only)
//   push, pop   : enqueue din / dequeue head; the caller never pushes when full
//                 and never pops when empty
//   din, head   : entry in / oldest entry out (head is valid when !empty)
//   full, empty : occupancy flags
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the count alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU (source 0)
// and the LSU load return (source 1). Each source has its own FIFO. A
// round-robin arbiter pops one head per cycle, and the winner is registered
// onto the register-file write inputs. Writes to x0 are accepted but dropped.
// Ports:
//   clk_pi, reset_pi        : clock, synchronous active-high reset
//   alu_valid/ready/rd/data : ALU writeback handshake and payload
//   lsu_valid/ready/rd/data : LSU writeback handshake and payload
//   destReg_po, we_po,
//   writeData_po            : registered register-file write port
//   pending_po              : registered FIFO non-empty flags (bit0 ALU, bit1 LSU)
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5
) (
  input  logic              clk_pi,
  input  logic              reset_pi,
  input  logic              alu_valid_pi,
  output logic              alu_ready_po,
  input  logic [REG_AW-1:0] alu_rd_pi,
  input  logic [DATA_W-1:0] alu_data_pi,
  input  logic              lsu_valid_pi,
  output logic              lsu_ready_po,
  input  logic [REG_AW-1:0] lsu_rd_pi,
  input  logic [DATA_W-1:0] lsu_data_pi,
  output logic [REG_AW-1:0] destReg_po,
  output logic              we_po,
  output logic [DATA_W-1:0] writeData_po,
  output logic [1:0]        pending_po
);

  import rv_wb_pkg::*;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic   alu_full, alu_empty, lsu_full, lsu_empty;
  logic   alu_push, lsu_push, alu_pop, lsu_pop;
  entry_t alu_in, lsu_in, alu_head, lsu_head;
  logic   last_grant;
  logic   win_lsu_p0;
  logic   vld_p0;
  entry_t win_p0;

  // ---- Stage p0: accept, x0 filter, arbitrate on FIFO heads ----
  // Ready follows the FIFO count only. A pop in the same cycle does not
  // reopen a full FIFO.
  assign alu_ready_po = !alu_full && !reset_pi;
  assign lsu_ready_po = !lsu_full && !reset_pi;

  // x0 writes complete the handshake but never occupy a slot
  assign alu_push = alu_valid_pi && alu_ready_po && (alu_rd_pi != '0);
  assign lsu_push = lsu_valid_pi && lsu_ready_po && (lsu_rd_pi != '0);

  assign alu_in = '{rd: alu_rd_pi, data: alu_data_pi};
  assign lsu_in = '{rd: lsu_rd_pi, data: lsu_data_pi};

  wb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_alu_fifo (
    .clk   (clk_pi),
    .rst   (reset_pi),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_in),
    .head  (alu_head),
    .full  (alu_full),
    .empty (alu_empty)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_lsu_fifo (
    .clk   (clk_pi),
    .rst   (reset_pi),
    .push  (lsu_push),
    .pop   (lsu_pop),
    .din   (lsu_in),
    .head  (lsu_head),
    .full  (lsu_full),
    .empty (lsu_empty)
  );

  assign vld_p0     = !alu_empty || !lsu_empty;
  assign win_lsu_p0 = rr_pick_lsu(!alu_empty, !lsu_empty, last_grant);
  assign alu_pop    = vld_p0 && !win_lsu_p0;
  assign lsu_pop    = vld_p0 && win_lsu_p0;
  assign win_p0     = win_lsu_p0 ? lsu_head : alu_head;

  // ---- Stage p1: registered register-file write port ----
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      we_po        <= 1'b0;
      destReg_po   <= '0;
      writeData_po <= '0;
      pending_po   <= '0;
      last_grant   <= 1'(SRC_LSU);
    end else begin
      we_po               <= vld_p0;
      pending_po[SRC_ALU] <= !alu_empty;
      pending_po[SRC_LSU] <= !lsu_empty;
      if (vld_p0) begin
        destReg_po   <= win_p0.rd;
        writeData_po <= win_p0.data;
        last_grant   <= win_lsu_p0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import rv_wb_pkg::*;

  logic              clk_pi;
  logic              reset_pi;
  logic              alu_valid_pi, lsu_valid_pi;
  logic              alu_ready_po, lsu_ready_po;
  logic [REG_AW-1:0] alu_rd_pi, lsu_rd_pi;
  logic [DATA_W-1:0] alu_data_pi, lsu_data_pi;
  logic [REG_AW-1:0] destReg_po;
  logic              we_po;
  logic [DATA_W-1:0] writeData_po;
  logic [1:0]        pending_po;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk_pi       (clk_pi),
    .reset_pi     (reset_pi),
    .alu_valid_pi (alu_valid_pi),
    .alu_ready_po (alu_ready_po),
    .alu_rd_pi    (alu_rd_pi),
    .alu_data_pi  (alu_data_pi),
    .lsu_valid_pi (lsu_valid_pi),
    .lsu_ready_po (lsu_ready_po),
    .lsu_rd_pi    (lsu_rd_pi),
    .lsu_data_pi  (lsu_data_pi),
    .destReg_po   (destReg_po),
    .we_po        (we_po),
    .writeData_po (writeData_po),
    .pending_po   (pending_po)
  );

  initial clk_pi = 1'b0;
  always #5 clk_pi = ~clk_pi;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] edat;
    logic [1:0]  epend;
    logic        ear;
    logic        elr;
  } vec_t;

  vec_t      vt[11];
  int        passed = 0;
  int        total  = 0;
  wb_entry_t exp_alu[$];
  wb_entry_t exp_lsu[$];
  wb_entry_t got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    alu_valid_pi = av;  alu_rd_pi = ard;  alu_data_pi = adat;
    lsu_valid_pi = lv;  lsu_rd_pi = lrd;  lsu_data_pi = ldat;
  endtask

  // One clock with reset low; records accepted pushes and observed writes
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     output logic ar, output logic lr);
    @(negedge clk_pi);
    reset_pi = 1'b0;
    drive(av, ard, adat, lv, lrd, ldat);
    #1;
    ar = alu_ready_po;
    lr = lsu_ready_po;
    if (av && ar && ard != 0) exp_alu.push_back('{rd: ard, data: adat});
    if (lv && lr && lrd != 0) exp_lsu.push_back('{rd: lrd, data: ldat});
    if (we_po) got.push_back('{rd: destReg_po, data: writeData_po});
  endtask

  task automatic do_reset();
    @(negedge clk_pi);
    reset_pi = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    exp_alu.delete();
    exp_lsu.delete();
    got.delete();
  endtask

  // Drain, then compare each source's write order with its accepted order
  task automatic score(input string tag);
    wb_entry_t ga[$];
    wb_entry_t gl[$];
    logic ar, lr;
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, ar, lr);
    foreach (got[i]) begin
      if (got[i].rd[4]) gl.push_back(got[i]);
      else ga.push_back(got[i]);
    end
    chk({tag, "_alu_n"}, ga.size(), exp_alu.size());
    chk({tag, "_lsu_n"}, gl.size(), exp_lsu.size());
    for (int i = 0; i < ga.size() && i < exp_alu.size(); i++)
      chk($sformatf("%s_alu%0d", tag, i), ga[i], exp_alu[i]);
    for (int i = 0; i < gl.size() && i < exp_lsu.size(); i++)
      chk($sformatf("%s_lsu%0d", tag, i), gl[i], exp_lsu[i]);
  endtask

  initial begin
    logic ar, lr;
    logic [9:0] exp_ar3, exp_lr3;
    int n_alu3, n_lsu3;

    // rst av ard adat lv lrd ldat | we rd data pend ar lr
    vt[0]  = '{1, 0, 0, 0,     0, 0, 0,          0, 0, 0,     0, 0, 0};
    vt[1]  = '{0, 1, 5, 'h11,  0, 0, 0,          0, 0, 0,     0, 1, 1};
    vt[2]  = '{0, 0, 0, 0,     0, 0, 0,          0, 0, 0,     0, 1, 1};
    vt[3]  = '{0, 0, 0, 0,     0, 0, 0,          1, 5, 'h11,  1, 1, 1};
    vt[4]  = '{1, 0, 0, 0,     0, 0, 0,          0, 5, 'h11,  0, 0, 0};
    vt[5]  = '{0, 1, 3, 'hAA,  1, 4, 'hBB,       0, 0, 0,     0, 1, 1};
    vt[6]  = '{0, 0, 0, 0,     0, 0, 0,          0, 0, 0,     0, 1, 1};
    vt[7]  = '{0, 0, 0, 0,     0, 0, 0,          1, 3, 'hAA,  3, 1, 1};
    vt[8]  = '{0, 0, 0, 0,     1, 0, 'hDEAD,     1, 4, 'hBB,  2, 1, 1};
    vt[9]  = '{0, 0, 0, 0,     0, 0, 0,          0, 4, 'hBB,  0, 1, 1};
    vt[10] = '{0, 0, 0, 0,     0, 0, 0,          0, 4, 'hBB,  0, 1, 1};

    reset_pi = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_pi);

    // Reset, single ALU write latency, simultaneous pushes, x0 drop
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_pi);
      reset_pi = vt[i].rst;
      drive(vt[i].av, vt[i].ard, vt[i].adat, vt[i].lv, vt[i].lrd, vt[i].ldat);
      #1;
      chk($sformatf("v%0d_we", i),    we_po,        vt[i].ewe);
      chk($sformatf("v%0d_rd", i),    destReg_po,   vt[i].erd);
      chk($sformatf("v%0d_data", i),  writeData_po, vt[i].edat);
      chk($sformatf("v%0d_pend", i),  pending_po,   vt[i].epend);
      chk($sformatf("v%0d_aready", i), alu_ready_po, vt[i].ear);
      chk($sformatf("v%0d_lready", i), lsu_ready_po, vt[i].elr);
    end

    // Sustained contention: ready toggles, writes alternate, nothing lost
    exp_ar3 = 10'b0101010111;  // bit k = ALU ready in cycle k
    exp_lr3 = 10'b1010101011;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(1, 5'(1 + k % 8), 32'hA000 + k, 1, 5'(16 + k % 8), 32'hB000 + k, ar, lr);
      chk($sformatf("t3_aready%0d", k), ar, exp_ar3[k]);
      chk($sformatf("t3_lready%0d", k), lr, exp_lr3[k]);
    end
    n_alu3 = exp_alu.size();
    n_lsu3 = exp_lsu.size();
    chk("t3_alu_accepted", n_alu3, 6);
    chk("t3_lsu_accepted", n_lsu3, 6);
    score("t3");
    chk("t3_writes", got.size(), 12);
    for (int i = 1; i < got.size(); i++)
      chk($sformatf("t3_alt%0d", i), got[i].rd[4], !got[i-1].rd[4]);

    // ALU FIFO fills while the LSU floods; full blocks even on a pop cycle
    do_reset();
    cyc(1, 1, 'hA0, 1, 16, 'hB0, ar, lr);
    chk("t5_c0", {ar, lr}, 2'b11);
    cyc(1, 2, 'hA1, 1, 17, 'hB1, ar, lr);
    chk("t5_c1", {ar, lr}, 2'b11);
    cyc(1, 3, 'hA2, 1, 18, 'hB2, ar, lr);
    chk("t5_c2", {ar, lr}, 2'b10);
    cyc(1, 4, 'hA3, 1, 18, 'hB2, ar, lr);
    chk("t5_full_block", {ar, lr}, 2'b01);
    cyc(1, 4, 'hA3, 1, 19, 'hB3, ar, lr);
    chk("t5_c4", {ar, lr}, 2'b10);
    chk("t5_alu_accepted", exp_alu.size(), 4);
    score("t5");

    // Reset mid-operation discards queued entries and the staged write
    do_reset();
    cyc(1, 7, 'h77, 1, 8, 'h88, ar, lr);
    cyc(1, 9, 'h99, 0, 0, 0, ar, lr);
    @(negedge clk_pi);
    reset_pi = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t6_we_before", we_po, 1'b1);
    chk("t6_pend_before", pending_po, 2'b11);
    cyc(0, 0, 0, 0, 0, 0, ar, lr);
    chk("t6_we_after", we_po, 1'b0);
    chk("t6_pend_after", pending_po, 2'b00);
    chk("t6_ready_after", {ar, lr}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0, ar, lr);
      chk($sformatf("t6_we_idle%0d", k), we_po, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
